// File: rtl/conversor_bcd_produto.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Sits after the 8x8 multiplier and feeds the 7-segment decoding stage.
module conversor_bcd_produto #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CONV = 2'b01
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    out_q, out_d;
   logic             done_q, done_d;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    work_nx;

   // One iteration: add 3 to every digit >= 5, then shift in the next bit
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = work_q[4*i +: 4];
      end
      work_nx = (adj << 1) | {{(BW-1){1'b0}}, shift_q[WIDTH-1]};
   end

   // State and datapath registers, async clear to the idle/zero state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   // Next state: accept in IDLE, iterate in CONV, publish on last bit
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CONV;
               shift_d = bin_in;
               work_d  = '0;
               cnt_d   = CW'(WIDTH);
            end
         end
         S_CONV: begin
            work_d  = work_nx;
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               out_d   = work_nx;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      busy    = (state_q == S_CONV);
      ready   = ~busy;
      done    = done_q;
      bcd_out = out_q;
   end

endmodule

// File: tb/tb_conversor_bcd_produto.sv
// Self-checking bench for conversor_bcd_produto.
// Reference result is the decimal expansion of the input computed arithmetically.
module tb_conversor_bcd_produto;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] bin_in;
   logic        busy;
   logic        ready;
   logic        done;
   logic [19:0] bcd_out;

   int pass_cnt = 0;
   int total_cnt = 0;

   conversor_bcd_produto #(.WIDTH(16), .DIGITS(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .ready   (ready),
      .done    (done),
      .bcd_out (bcd_out)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Drives one request and observes latency, busy length, hold and result.
   task automatic conv(input bit now, input logic [15:0] v,
                       output int lat, output int busy_n,
                       output bit hold_ok, output logic [19:0] res);
      logic [19:0] prev;
      if (!now) @(negedge clk);
      prev = bcd_out;
      start = 1'b1;
      bin_in = v;
      @(posedge clk);
      lat = -1;
      busy_n = 0;
      hold_ok = 1'b1;
      res = 20'hx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         bin_in = 16'($urandom);
         if (busy) busy_n++;
         if (done) begin
            lat = c - 1;
            res = bcd_out;
            break;
         end
         if (bcd_out !== prev) hold_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      bin_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({busy, ready, done, bcd_out} !== {1'b0, 1'b1, 1'b0, 20'h0})
         $display("FAIL reset_in: busy/ready/done/bcd=%b%b%b %h need 010 00000",
                  busy, ready, done, bcd_out);
      else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({busy, ready, done, bcd_out} !== {1'b0, 1'b1, 1'b0, 20'h0})
         $display("FAIL reset_out: busy/ready/done/bcd=%b%b%b %h need 010 00000",
                  busy, ready, done, bcd_out);
      else pass_cnt++;
   endtask

   task automatic test_max_product;
      int lat, bn;
      bit hold;
      logic [19:0] res;
      conv(1'b0, 16'd65025, lat, bn, hold, res);
      total_cnt++;
      if (res !== 20'h65025)
         $display("FAIL p65025_result: got %h need 65025", res);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 16)
         $display("FAIL p65025_latency: got %0d need 16", lat);
      else pass_cnt++;
      total_cnt++;
      if (bn !== 16)
         $display("FAIL p65025_busy_len: got %0d need 16", bn);
      else pass_cnt++;
      total_cnt++;
      if (hold !== 1'b1)
         $display("FAIL p65025_hold: bcd_out changed during CONV");
      else pass_cnt++;
   endtask

   task automatic test_values;
      logic [15:0] vals [3];
      logic [19:0] exps [3];
      int lat, bn;
      bit hold;
      logic [19:0] res;
      vals = '{16'd0, 16'd99, 16'd65535};
      exps = '{20'h00000, 20'h00099, 20'h65535};
      for (int i = 0; i < 3; i++) begin
         conv(1'b0, vals[i], lat, bn, hold, res);
         total_cnt++;
         if (res !== exps[i] || res !== to_bcd(vals[i]))
            $display("FAIL value_%0d: got %h need %h", vals[i], res, exps[i]);
         else pass_cnt++;
         total_cnt++;
         if (hold !== 1'b1 || lat !== 16)
            $display("FAIL value_%0d_hold: hold=%0d lat=%0d need 1,16",
                     vals[i], hold, lat);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      int lat, bn;
      bit hold;
      logic [19:0] res;
      @(negedge clk);
      start = 1'b1;
      bin_in = 16'd1234;
      @(posedge clk);
      lat = -1;
      res = 20'hx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 5) begin
            start = 1'b1;
            bin_in = 16'd9999;
         end
         if (done) begin
            lat = c - 1;
            res = bcd_out;
            break;
         end
      end
      total_cnt++;
      if (res !== 20'h01234 || lat !== 16)
         $display("FAIL ignore_busy_start: got %h lat %0d need 01234 lat 16",
                  res, lat);
      else pass_cnt++;
      conv(1'b1, 16'd9999, lat, bn, hold, res);
      total_cnt++;
      if (res !== 20'h09999)
         $display("FAIL b2b_result: got %h need 09999", res);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 16 || bn !== 16)
         $display("FAIL b2b_timing: lat=%0d busy=%0d need 16,16", lat, bn);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int lat, bn;
      bit hold;
      logic [19:0] res;
      @(negedge clk);
      start = 1'b1;
      bin_in = 16'd4321;
      @(posedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({busy, ready, done, bcd_out} !== {1'b0, 1'b1, 1'b0, 20'h0})
         $display("FAIL reset_abort: busy/ready/done/bcd=%b%b%b %h need 010 00000",
                  busy, ready, done, bcd_out);
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_no_done: done=%b busy=%b need 0,0", done, busy);
      else pass_cnt++;
      conv(1'b0, 16'd50, lat, bn, hold, res);
      total_cnt++;
      if (res !== 20'h00050 || lat !== 16)
         $display("FAIL after_reset: got %h lat %0d need 00050 lat 16", res, lat);
      else pass_cnt++;
   endtask

   task automatic test_held_start;
      int last, pulses;
      bit prev_done;
      @(negedge clk);
      start = 1'b1;
      bin_in = 16'd100;
      last = -1;
      pulses = 0;
      prev_done = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (done) begin
            total_cnt++;
            if (bcd_out !== 20'h00100 || prev_done)
               $display("FAIL held_result: got %h dbl=%0d need 00100",
                        bcd_out, prev_done);
            else pass_cnt++;
            if (last >= 0) begin
               total_cnt++;
               if (c - last !== 17)
                  $display("FAIL held_period: got %0d need 17", c - last);
               else pass_cnt++;
            end
            pulses++;
            last = c;
         end
         prev_done = done;
      end
      total_cnt++;
      if (pulses !== 4)
         $display("FAIL held_pulses: got %0d need 4", pulses);
      else pass_cnt++;
      start = 1'b0;
      for (int c = 0; c < 20 && busy; c++) @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0)
         $display("FAIL held_drain: busy=%b need 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_random;
      int lat, bn;
      bit hold;
      logic [19:0] res;
      int unsigned a, b, p;
      for (int n = 0; n < 200; n++) begin
         a = $urandom_range(255);
         b = $urandom_range(255);
         p = a * b;
         conv(1'b0, 16'(p), lat, bn, hold, res);
         total_cnt++;
         if (res !== to_bcd(p) || lat !== 16)
            $display("FAIL rand_%0dx%0d: got %h lat %0d need %h lat 16",
                     a, b, res, lat, to_bcd(p));
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset;
      test_max_product;
      test_values;
      test_back_to_back;
      test_reset_mid;
      test_held_start;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/conversor_bcd_produto.md
Name: conversor_bcd_produto

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that sits directly downstream of the 8x8 multiplier.
- Takes the 16-bit product and produces packed BCD digits for the display-decoding stage (7-segment drivers).
- Performs one iteration per clock, with a start/busy/done handshake.
- Holds the last converted result stable until the next conversion completes.

Parameters:
- WIDTH, 16, width of the binary input. Multiplier product width.
- DIGITS, 5, number of BCD output digits. Requirement: 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  WIDTH  binary value (multiplier product P); captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- ready  output  1  equals not busy; a start is accepted this cycle.
- done  output  1  single-cycle pulse when bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit i in bits [4i+3:4i]; digit 0 is the units digit.

Behaviour:
- Interface: one clock domain (clk). Reset is asynchronous, active-high (reset).
- Reset values: busy=0, ready=1, done=0, bcd_out=0, state=IDLE, internal shift and BCD registers and iteration counter=0.
- States:
  - IDLE: waiting for start.
  - CONV: iterating.
  - No other states. Any illegal encoding returns to IDLE.
- IDLE -> CONV:
  - Occurs on the edge where start=1.
  - On that edge: bin_in is loaded into the shift register, the BCD working register is cleared, and the counter is set to WIDTH.
  - busy=1 from that edge onward.
- CONV, each edge performs one iteration:
  - Every working BCD digit >= 5 gets +3.
  - Then {bcd_work, shift_reg} shifts left by 1; the shift register MSB enters BCD bit 0.
  - The counter decrements.
- CONV -> IDLE:
  - Occurs on the edge completing iteration WIDTH, i.e. the WIDTH-th edge after the accepting edge.
  - On that edge: bcd_out is loaded with the final working value, busy=0, and done=1 for exactly the following cycle.
- Latency: if start is accepted at edge k, bcd_out is valid and done=1 after edge k+WIDTH (16 cycles by default).
- Add-3 is applied to digits before the shift within the same iteration. It is not applied after the final shift.
- Result constraints:
  - The result is exact for all inputs 0..2^WIDTH-1.
  - The top digit never exceeds 6 for WIDTH=16.
  - The result is never truncated.
- bcd_out changes only on the completing edge or on reset. It is stable during CONV, showing the previous result.
- start while busy=1 is ignored; it is neither queued nor restarted.
- bin_in changes during CONV have no effect, because the value was captured at acceptance.
- Back-to-back: start=1 in the cycle where done=1 is accepted (state is IDLE). The new conversion begins, and done from the previous conversion is not extended.
- start held high continuously: a new conversion starts on every IDLE cycle, so done pulses every WIDTH+1 cycles.
- Reset mid-conversion:
  - Immediate abort: outputs return to reset values, including bcd_out=0.
  - No done pulse is generated.
- done is registered, not combinational, and never high for two consecutive cycles.

Test Plan:
- Reset, then start with bin_in=16'd65025 (255*255): bcd_out=20'h65025, done pulses exactly 16 cycles after the accepting edge, and busy is high for exactly 16 cycles.
- bin_in=0, then bin_in=16'd99, then bin_in=16'd65535: bcd_out=20'h00000, 20'h00099 and 20'h65535 respectively. bcd_out holds the old value throughout each CONV.
- Start with 16'd1234, pulse start again with 16'd9999 at cycle 5 of CONV: that start is ignored and the result is 20'h01234. Then start with 16'd9999 in the done cycle: accepted, result 20'h09999 after a further 16 cycles.
- Start with 16'd4321, assert reset asynchronously at cycle 7 of CONV: busy=0, bcd_out=0 and done=0 immediately. After reset release, start with 16'd50: result 20'h00050.
- Start held at 1 continuously with bin_in=16'd100: done pulses every 17 cycles, bcd_out=20'h00100 every time.
- Randomised: multiplier P output for 200 random A,B feeding bin_in: bcd_out matches the decimal value of A*B in every case.
